// File: rtl/camera_capture.sv
// rtl/camera_capture.sv - RGB565 camera byte stream to RGB444 pixel writer
//
// Captures frames from a parallel CMOS sensor, packs byte pairs into
// RGB444 pixels with a linear write address, and checks frame geometry.
//
// Ports:
//   p_clk            camera pixel clock, all logic on rising edge
//   rst_n            asynchronous active-low reset
//   cmos_vsync       high during vertical blanking
//   cmos_href        high while active line bytes are on cmos_data
//   cmos_data[7:0]   RGB565 bytes, high byte first
//   pixel_data[11:0] RGB444 pixel
//   pixel_valid      one-cycle strobe for pixel_data / pixel_addr
//   pixel_addr[18:0] y*H_ACTIVE+x of the strobed pixel
//   cmos_frame_done  low only while a frame is being captured
//   frame_err        last completed frame had wrong geometry
//   frame_count[7:0] completed frames, wraps
module camera_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        p_clk,
    input  logic        rst_n,
    input  logic        cmos_vsync,
    input  logic        cmos_href,
    input  logic [7:0]  cmos_data,
    output logic [11:0] pixel_data,
    output logic        pixel_valid,
    output logic [18:0] pixel_addr,
    output logic        cmos_frame_done,
    output logic        frame_err,
    output logic [7:0]  frame_count
);

    localparam logic [10:0] H_X   = 11'(H_ACTIVE);
    localparam logic [10:0] V_Y   = 11'(V_ACTIVE);
    localparam logic [18:0] H_INC = 19'(H_ACTIVE);
    localparam logic [10:0] X_MAX = 11'd2047;
    localparam logic [9:0]  Y_MAX = 10'd1023;

    typedef enum logic [1:0] {SYNC, VBLANK, CAPTURE} state_t;

    state_t      state;
    logic        phase;
    logic [6:0]  hi_bits;    // only the high-byte bits that survive the RGB444 reduction
    logic [10:0] x;
    logic [9:0]  y;
    logic [18:0] line_base;  // y*H_ACTIVE kept by addition
    logic        href_q;
    logic        line_err;

    // A frame ending with a line still open (vsync rising during href)
    // counts that line as if its href had fallen.
    logic        open_line;
    logic        open_err;
    logic [10:0] y_end;

    always_comb begin
        open_line = 1'b0;
        open_err  = 1'b0;
        y_end     = {1'b0, y};
        if (x != 11'd0) begin
            open_line = 1'b1;
            open_err  = (x != H_X);
            y_end     = {1'b0, y} + 11'd1;
        end
    end

    always_ff @(posedge p_clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= SYNC;
            phase           <= 1'b0;
            hi_bits         <= '0;
            x               <= '0;
            y               <= '0;
            line_base       <= '0;
            href_q          <= 1'b0;
            line_err        <= 1'b0;
            pixel_data      <= '0;
            pixel_valid     <= 1'b0;
            pixel_addr      <= '0;
            cmos_frame_done <= 1'b1;
            frame_err       <= 1'b0;
            frame_count     <= '0;
        end else begin
            href_q      <= cmos_href;
            pixel_valid <= 1'b0;
            case (state)
                SYNC: begin
                    cmos_frame_done <= 1'b1;
                    if (cmos_vsync) begin
                        state <= VBLANK;
                    end
                end
                VBLANK: begin
                    x         <= '0;
                    y         <= '0;
                    line_base <= '0;
                    phase     <= 1'b0;
                    if (!cmos_vsync) begin
                        state           <= CAPTURE;
                        cmos_frame_done <= 1'b0;
                    end
                end
                default: begin
                    if (cmos_vsync) begin
                        state           <= VBLANK;
                        cmos_frame_done <= 1'b1;
                        frame_err       <= line_err | open_err | (y_end != V_Y);
                        line_err        <= 1'b0;
                        frame_count     <= frame_count + 8'd1;
                        phase           <= 1'b0;
                    end else if (cmos_href) begin
                        if (!phase) begin
                            hi_bits <= {cmos_data[7:4], cmos_data[2:0]};
                            phase   <= 1'b1;
                        end else begin
                            phase      <= 1'b0;
                            pixel_data <= {hi_bits, cmos_data[7], cmos_data[4:1]};
                            // Out-of-range pixels still advance x so the line
                            // length check sees the true count.
                            if (x < H_X && {1'b0, y} < V_Y) begin
                                pixel_valid <= 1'b1;
                                pixel_addr  <= line_base + 19'(x);
                            end
                            if (x != X_MAX) begin
                                x <= x + 11'd1;
                            end
                        end
                    end else begin
                        phase <= 1'b0;
                        if (href_q && x != 11'd0) begin
                            x         <= '0;
                            line_base <= line_base + H_INC;
                            if (y != Y_MAX) begin
                                y <= y + 10'd1;
                            end
                            if (x != H_X) begin
                                line_err <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // open_line is folded into y_end/open_err; kept as a named term for clarity
    logic unused_open;
    assign unused_open = open_line;

endmodule

// File: doc/camera_capture.md
CAMERA_CAPTURE -- requirements
Module: camera_capture

Interface
REQ-001 Parameter H_ACTIVE, default 640, pixels per active line.
REQ-002 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 p_clk  input  1  camera pixel clock; the block's only clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmos_vsync  input  1  camera VSYNC; high = vertical blanking.
REQ-006 cmos_href  input  1  camera HREF; high = active line bytes on cmos_data.
REQ-007 cmos_data  input  8  camera byte bus, RGB565, high byte first.
REQ-008 pixel_data  output  12  RGB444 pixel.
REQ-009 pixel_valid  output  1  one-cycle strobe; pixel_data/pixel_addr valid.
REQ-010 pixel_addr  output  19  linear write address, y*H_ACTIVE+x.
REQ-011 cmos_frame_done  output  1  level; high whenever no frame is being captured.
REQ-012 frame_err  output  1  last completed frame had wrong geometry.
REQ-013 frame_count  output  8  completed-frame counter.

Function
REQ-014 FSM states SHALL be SYNC, VBLANK, CAPTURE.
REQ-015 SYNC: wait for sampled cmos_vsync=1, then go to VBLANK; pixels ignored (discards partial frame after reset).
REQ-016 VBLANK: on sampled cmos_vsync=0 go to CAPTURE; x, y, pixel_addr, byte phase cleared on entry.
REQ-017 CAPTURE: on sampled cmos_vsync=1 go to VBLANK and perform end-of-frame actions (REQ-025..027).
REQ-018 cmos_frame_done SHALL be 0 exactly while state is CAPTURE, 1 otherwise, registered (changes one cycle after the vsync sample causing the transition).
REQ-019 In CAPTURE with cmos_href=1, bytes alternate: phase 0 stores cmos_data as high byte, phase 1 completes the pixel; phase toggles each href-high cycle.
REQ-020 cmos_href=0 SHALL reset phase to 0; an odd trailing byte is discarded.
REQ-021 On pixel completion (hi,lo): pixel_data = {hi[7:4], hi[2:0],lo[7], lo[4:1]}, i.e. R565[4:1], G565[5:2], B565[4:1]; pixel_valid=1 the following cycle for exactly one cycle; latency one p_clk from the low-byte sample edge.
REQ-022 pixel_valid SHALL be asserted only if x<H_ACTIVE and y<V_ACTIVE; excess pixels/lines dropped, counters still tracked for error detection (x, y saturate at 2047 / 1023).
REQ-023 pixel_addr SHALL equal y*H_ACTIVE+x of the emitted pixel, maintained by increment (no multiplier); first pixel of frame = 0, last = H_ACTIVE*V_ACTIVE-1 (307199).
REQ-024 Falling cmos_href (sampled 1 then 0) in CAPTURE: if x>0, y increments and x clears; a line with x≠H_ACTIVE sets internal line-error flag.
REQ-025 End of frame: frame_err <= (line-error flag) or (y≠V_ACTIVE); line-error flag cleared.
REQ-026 End of frame: frame_count increments, wrapping 255->0.
REQ-027 vsync rising while cmos_href=1 SHALL end the frame; the in-progress line counts as a line for y and error checking.
REQ-028 pixel_valid SHALL never be asserted outside CAPTURE (except the REQ-021 strobe from the final completing edge).

Reset
REQ-029 rst_n=0 SHALL immediately force: state SYNC, pixel_valid 0, pixel_data 0, pixel_addr 0, cmos_frame_done 1, frame_err 0, frame_count 0, phase 0, x=y=0.
REQ-030 Reset release mid-frame SHALL produce no pixel_valid until a full VBLANK->CAPTURE sequence is seen.

Verification
REQ-031 Reset, then 2 full 640x480 frames with bytes hi=0xF8,lo=0x1F -> 307200 strobes/frame, pixel_data=0xF0F, addr 0..307199, frame_err=0, frame_count=2.
REQ-032 Release reset mid-CAPTURE (vsync low, href active) -> zero strobes until next vsync fall; first strobe addr=0.
REQ-033 One line with 639 pixels in 640x480 frame -> frame_err=1 after that frame; next good frame -> frame_err=0.
REQ-034 Line with 641 pixels plus odd trailing byte -> 640 strobes for that line, trailing byte dropped, frame_err=1.
REQ-035 Small params H_ACTIVE=4, V_ACTIVE=2, 255->0 wrap: run 256 frames -> frame_count=0, cmos_frame_done low only during vsync-low windows.
REQ-036 vsync rises with href high mid-line -> frame ends immediately, cmos_frame_done=1 next cycle, no further strobes.
